// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide beside the EX-stage ALU.
// Radix-2 shift-add multiplier and restoring divider on shared hi/lo regs.
module muldiv_unit #(
  parameter  int N  = 32,
  localparam int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         div_by_zero,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [N-1:0]   ONE  = N'(1);
  localparam logic [2*N-1:0] ONE2 = (2*N)'(1);
  localparam logic [N-1:0]   MINV = {1'b1, {(N-1){1'b0}}};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  b_q, b_d;
  logic          qneg_q, qneg_d;
  logic          rneg_q, rneg_d;
  logic [N-1:0]  res_q, res_d;
  logic          dbz_q, dbz_d;

  logic          a_sgn, b_sgn, sa, sb;
  logic [N-1:0]  mag_a, mag_b;
  logic          dz, ovf;
  logic [N:0]    sum, shl, diff;
  logic [N-1:0]  hi_n, lo_n;
  logic [2*N-1:0] prod_s;
  logic [N-1:0]  quot_s, rem_s, fin;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign result      = res_q;
  assign div_by_zero = dbz_q;

  // Operand sign decode and magnitude conversion at accept
  always_comb begin
    a_sgn = (op == 3'b001) || (op == 3'b010) ||
            (op == 3'b100) || (op == 3'b110);
    b_sgn = (op == 3'b001) || (op == 3'b100) ||
            (op == 3'b110);
    sa    = a_sgn & A[N-1];
    sb    = b_sgn & B[N-1];
    mag_a = sa ? ~A + ONE : A;
    mag_b = sb ? ~B + ONE : B;
    dz    = op[2] && (B == '0);
    ovf   = op[2] && !op[0] && (A == MINV) && (B == '1);
  end

  // One multiply or divide step, then sign fix-up and result select
  always_comb begin
    sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : '0)};
    shl  = {hi_q, lo_q[N-1]};
    diff = shl - {1'b0, b_q};
    if (op_q[2]) begin
      hi_n = diff[N] ? shl[N-1:0] : diff[N-1:0];
      lo_n = {lo_q[N-2:0], ~diff[N]};
    end else begin
      hi_n = sum[N:1];
      lo_n = {sum[0], lo_q[N-1:1]};
    end
    prod_s = qneg_q ? ~{hi_n, lo_n} + ONE2 : {hi_n, lo_n};
    quot_s = qneg_q ? ~lo_n + ONE : lo_n;
    rem_s  = rneg_q ? ~hi_n + ONE : hi_n;
    fin    = '0;
    unique case (1'b1)
      (op_q == 3'b000):            fin = prod_s[N-1:0];
      (!op_q[2] && op_q != 3'b0):  fin = prod_s[2*N-1:N];
      (op_q[2] && !op_q[1]):       fin = quot_s;
      (op_q[2] && op_q[1]):        fin = rem_s;
      default:                     fin = '0;
    endcase
  end

  // Next-state logic: accept, iterate, hold result until taken
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d   = op;
          hi_d   = '0;
          lo_d   = mag_a;
          b_d    = mag_b;
          qneg_d = sa ^ sb;
          rneg_d = sa;
          dbz_d  = 1'b0;
          cnt_d  = '0;
          if (dz) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            res_d   = op[1] ? A : '1;
          end else if (ovf) begin
            state_d = DONE;
            res_d   = op[1] ? '0 : A;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = hi_n;
        lo_d  = lo_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = fin;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M execute unit. Sits beside the single-cycle N-bit ALU in EX.
- Performs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on N-bit operands.
- Uses an iterative radix-2 shift-add multiplier and a restoring divider.
- Valid/ready handshakes on both sides; the pipeline stalls on in_ready=0 or until out_valid.

Parameters:
- N, 32, operand/result width; even, ≥8.
- CW, $clog2(N)+1, iteration-counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A  in  N  rs1 operand
- B  in  N  rs2 operand
- out_valid  out  1  result valid; held until taken
- out_ready  in  1  consumer accepts result
- result  out  N  registered result
- div_by_zero  out  1  registered; high with out_valid when a DIV/DIVU/REM/REMU had B==0
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counter=0.
  - result=0, out_valid=0, div_by_zero=0, busy=0, in_ready=1 once rst_n releases.
  - In-flight operation discarded; no output produced for it.
- Accept: on a rising edge with in_valid&&in_ready, register op, A, B.
  - Later changes on A/B/op are ignored until the next accept.
- FSM IDLE -> CALC -> DONE -> IDLE.
  - IDLE→CALC on accept, normal case.
  - IDLE→DONE directly on accept, special case: divide by zero or signed overflow.
  - CALC→DONE when the counter reaches N.
  - DONE→IDLE on out_ready.
- Sign handling:
  - Signed operand: MULH: A and B; MULHSU: A only; DIV/REM: A and B.
  - Signed operands are converted to magnitude at accept. Result sign is recorded.
  - Magnitude core produces a 2N-bit product, or an N-bit quotient and remainder.
  - Final two's-complement negation is applied when entering DONE.
- Multiply: one partial product per cycle, N CALC cycles.
  - MUL returns product[N-1:0].
  - MULH/MULHSU/MULHU return product[2N-1:N].
  - Negative product = bitwise invert of the 2N-bit magnitude +1, applied before slicing.
- Divide: one quotient bit per cycle, N CALC cycles.
  - Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A).
- Special cases (no CALC, DONE on next edge):
  - B==0: quotient = all ones; remainder = A; div_by_zero=1.
  - Signed overflow (A = 1 followed by N-1 zeros, B = all ones, DIV/REM only): quotient = A; remainder = 0; div_by_zero=0.
- Latency from accept edge to out_valid high:
  - Normal: N+1 edges (33 for N=32).
  - Special case: 1 edge.
- Output handshake:
  - out_valid, result and div_by_zero are stable in DONE until the edge where out_ready=1.
  - On that edge out_valid drops and state returns to IDLE.
  - out_ready already high on DONE entry → exactly one out_valid cycle.
- No new accept while busy. The earliest back-to-back accept is the cycle after result handoff (in_ready=1 in IDLE).
- out_ready outside DONE is ignored.
- in_valid outside IDLE is ignored; the requester must hold it until in_ready.
- Counter wraps to 0 on leaving CALC.

Test Plan:
- Reset then MUL A=7, B=0xFFFFFFFD, out_ready=1 → out_valid exactly 33 edges after accept; result=0xFFFFFFEB; div_by_zero=0.
- Signed/unsigned high products:
  - MULH A=B=0x80000000 → 0x40000000.
  - MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU same operands → 0xFFFFFFFE.
- Signed divide:
  - DIV A=0xFFFFFFF9, B=2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU A=100, B=7 → 14.
  - REMU A=100, B=7 → 2.
- Special cases, each in 1 edge:
  - DIVU A=5, B=0 → 0xFFFFFFFF, div_by_zero=1.
  - REM A=5, B=0 → 5, div_by_zero=1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000, div_by_zero=0.
  - REM same operands → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and A/B toggling → result stable, in_ready=0, no new accept. Raise out_ready → one handoff; next accept on the following edge.
- Reset mid-operation: deassert rst_n 10 cycles into a DIV → out_valid, busy, result immediately 0. After release, a new MUL 3×4 returns 12 with no stale output.
